change_dispenser: RTL and testbench

Coin-return unit on the output side of the vending datapath. It accepts a refund amount over a valid/ready handshake and pays it out as a sequence of single-coin eject commands to three hoppers with denominations 4, 2 and 1. It tracks hopper inventory and detects jammed hoppers. When it cannot pay the full amount, it reports the unpaid remainder.

---
 rtl/change_dispenser.sv | 154 +++++++++++++++
 tb/tb_change_dispenser.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays a refund amount out as single-coin ejects from
// three hoppers (4, 2, 1), greedy largest-first. It tracks hopper inventory,
// detects jams by ack timeout and reports any unpaid remainder.
module change_dispenser #(
  parameter int AMT_W   = 4,
  parameter int INV_W   = 4,
  parameter int INV_MAX = 15,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic [2:0]       eject,
  input  logic             eject_ack,
  input  logic             restock,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [2:0]       inv_empty
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_WAIT_ACK, S_DONE
  } state_t;

  state_t                state_q;
  logic [AMT_W-1:0]      rem_q;
  logic [AMT_W-1:0]      short_q;
  // Selected coin, one-hot in eject bit order. Since bit2=4, bit1=2, bit0=1,
  // the one-hot vector read as a number is also the coin's value.
  logic [2:0]            sel_q;
  logic [2:0]            jam_q;
  logic [2:0][INV_W-1:0] inv_q;
  logic [TW-1:0]         tmo_q;
  logic                  ready_q, busy_q, done_q;
  logic [2:0]            eject_q;
  logic [2:0]            pick;

  // A hopper is unusable when it has run dry or has been flagged as jammed
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      inv_empty[i] = (inv_q[i] == '0) | jam_q[i];
    end
  end

  // Greedy choice: largest usable coin that does not exceed the remainder
  always_comb begin
    pick = 3'b000;
    if (rem_q >= AMT_W'(4) && !inv_empty[2])      pick = 3'b100;
    else if (rem_q >= AMT_W'(2) && !inv_empty[1]) pick = 3'b010;
    else if (rem_q != '0 && !inv_empty[0])        pick = 3'b001;
  end

  // Control FSM with registered Moore outputs, inventory and jam tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      short_q <= '0;
      sel_q   <= 3'b000;
      jam_q   <= 3'b000;
      for (int i = 0; i < 3; i++) inv_q[i] <= INV_W'(INV_MAX);
      tmo_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eject_q <= 3'b000;
    end else begin
      // Pulse outputs default low; they are raised only on entry to their state.
      done_q  <= 1'b0;
      eject_q <= 3'b000;
      case (state_q)
        S_IDLE: begin
          // Restock lands on the same edge as a request, so the first
          // SELECT already sees full hoppers.
          if (restock) begin
            jam_q <= 3'b000;
            for (int i = 0; i < 3; i++) inv_q[i] <= INV_W'(INV_MAX);
          end
          if (req_valid) begin
            rem_q   <= req_amount;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (req_amount == '0) begin
              short_q <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (pick != 3'b000) begin
            sel_q   <= pick;
            eject_q <= pick;
            state_q <= S_EJECT;
          end else begin
            short_q <= rem_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_EJECT: begin
          // An ack seen in this cycle belongs to nothing; it is ignored.
          tmo_q   <= '0;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (eject_ack) begin
            rem_q <= rem_q - AMT_W'(sel_q);
            for (int i = 0; i < 3; i++) begin
              if (sel_q[i] && inv_q[i] != '0) inv_q[i] <= inv_q[i] - INV_W'(1);
            end
            if (rem_q == AMT_W'(sel_q)) begin
              short_q <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SELECT;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            // TIMEOUT-th silent cycle: mark the hopper jammed, retry smaller coins.
            jam_q   <= jam_q | sel_q;
            state_q <= S_SELECT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign eject     = eject_q;
  assign shortfall = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected ejects and shortfalls are
// queued when a request is driven and popped as the DUT produces them.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, eject_ack, restock, sel;
  logic [3:0] req_amount;

  logic       rdy0, busy0, done0, rdy1, busy1, done1;
  logic [2:0] ej0, ej1, ie0, ie1;
  logic [3:0] sf0, sf1;

  logic       rdy_m, busy_m, done_m;
  logic [2:0] ej_m, ie_m;
  logic [3:0] sf_m;

  int ntot = 0;
  int nfail = 0;
  logic [2:0] ej_q[$];
  logic [3:0] sf_q[$];
  int first_ej, done_cyc;

  always #5 clk = ~clk;

  change_dispenser #(.AMT_W(4), .INV_W(4), .INV_MAX(15), .TIMEOUT(8)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_amount(req_amount), .req_ready(rdy0),
    .eject(ej0), .eject_ack(eject_ack & ~sel), .restock(restock & ~sel),
    .busy(busy0), .done(done0), .shortfall(sf0), .inv_empty(ie0));

  change_dispenser #(.AMT_W(4), .INV_W(4), .INV_MAX(1), .TIMEOUT(8)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_amount(req_amount), .req_ready(rdy1),
    .eject(ej1), .eject_ack(eject_ack & sel), .restock(restock & sel),
    .busy(busy1), .done(done1), .shortfall(sf1), .inv_empty(ie1));

  assign rdy_m  = sel ? rdy1  : rdy0;
  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign ej_m   = sel ? ej1   : ej0;
  assign ie_m   = sel ? ie1   : ie0;
  assign sf_m   = sel ? sf1   : sf0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and serve its ejects. The first `skips` ejects get no
  // ack (forcing a jam); rs_req pulses restock with the request, rs_mid
  // pulses restock on every ack cycle (state WAIT_ACK).
  task automatic run_req(input logic [3:0] amt, input int skips, input bit rs_req,
                         input bit rs_mid);
    int  cyc, n;
    bit  ack_nxt, got_done;
    logic [2:0] e;
    logic [3:0] s;
    n = 0;
    while (!rdy_m && n < 50) begin step(); n++; end
    req_valid = 1'b1; req_amount = amt; restock = rs_req;
    step();
    req_valid = 1'b0; restock = 1'b0;
    cyc = 1; ack_nxt = 1'b0; got_done = 1'b0; first_ej = -1; done_cyc = -1;
    while (!got_done && cyc < 200) begin
      eject_ack = ack_nxt;
      restock   = rs_mid & ack_nxt;
      ack_nxt   = 1'b0;
      if (ej_m != 3'b000) begin
        if (first_ej < 0) first_ej = cyc;
        if (ej_q.size() == 0) chk("unexpected_eject", ej_m, 3'b000);
        else begin e = ej_q.pop_front(); chk("eject", ej_m, e); end
        if (skips > 0) skips--; else ack_nxt = 1'b1;
      end
      if (done_m) begin
        got_done = 1'b1;
        done_cyc = cyc;
        s = (sf_q.size() != 0) ? sf_q.pop_front() : 4'hx;
        chk("shortfall", sf_m, s);
        chk("missing_ejects", ej_q.size(), 0);
      end else begin
        step();
        cyc++;
      end
    end
    eject_ack = 1'b0; restock = 1'b0;
    chk("req_timeout", got_done, 1);
    step();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_amount = '0; eject_ack = 1'b0;
    restock = 1'b0; sel = 1'b0;
    step(); step();
    chk("rst_ready", rdy_m, 1);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_eject", ej_m, 0);
    chk("rst_short", sf_m, 0);
    chk("rst_inv_empty", ie_m, 0);
    reset = 1'b0;
    step();

    // amount 7 on full hoppers: 4, 2, 1
    ej_q.push_back(3'b100); ej_q.push_back(3'b010); ej_q.push_back(3'b001);
    sf_q.push_back(4'd0);
    run_req(4'd7, 0, 1'b0, 1'b0);
    chk("amt7_first_eject_cycle", first_ej, 2);
    chk("amt7_done_cycle", done_cyc, 10);
    chk("amt7_inv_empty", ie_m, 3'b000);

    // zero amount: done one cycle after accept, busy for that one cycle only
    sf_q.push_back(4'd0);
    run_req(4'd0, 0, 1'b0, 1'b0);
    chk("amt0_done_cycle", done_cyc, 1);
    chk("amt0_first_eject", first_ej, -1);
    chk("amt0_busy_after", busy_m, 0);
    chk("amt0_ready_after", rdy_m, 1);

    // 4-coin jams; falls back to two 2-coins. Restock during WAIT_ACK ignored.
    ej_q.push_back(3'b100); ej_q.push_back(3'b010); ej_q.push_back(3'b010);
    sf_q.push_back(4'd0);
    run_req(4'd4, 1, 1'b0, 1'b1);
    chk("jam_done_cycle", done_cyc, 17);
    chk("jam_inv_empty", ie_m, 3'b100);

    // restock together with request in IDLE clears the jam before SELECT
    ej_q.push_back(3'b100);
    sf_q.push_back(4'd0);
    run_req(4'd4, 0, 1'b1, 1'b0);
    chk("restock_inv_empty", ie_m, 3'b000);

    // jam again, then reset in the middle of the next request
    ej_q.push_back(3'b100); ej_q.push_back(3'b010); ej_q.push_back(3'b010);
    sf_q.push_back(4'd0);
    run_req(4'd4, 1, 1'b0, 1'b0);
    chk("jam2_inv_empty", ie_m, 3'b100);
    req_valid = 1'b1; req_amount = 4'd4;
    step();
    req_valid = 1'b0;
    chk("mid_busy", busy_m, 1);
    step();
    chk("mid_eject", ej_m, 3'b010);
    step();
    reset = 1'b1;
    #1;
    chk("midrst_ready", rdy_m, 1);
    chk("midrst_busy", busy_m, 0);
    chk("midrst_eject", ej_m, 0);
    chk("midrst_inv_empty", ie_m, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_done", done_m, 0);
    end
    ej_q.push_back(3'b100); ej_q.push_back(3'b010); ej_q.push_back(3'b001);
    sf_q.push_back(4'd0);
    run_req(4'd7, 0, 1'b0, 1'b0);
    chk("post_rst_done_cycle", done_cyc, 10);

    // one coin per hopper: second request of 4 runs short by 1
    sel = 1'b1;
    step();
    ej_q.push_back(3'b100);
    sf_q.push_back(4'd0);
    run_req(4'd4, 0, 1'b0, 1'b0);
    chk("inv1_first_inv_empty", ie_m, 3'b100);
    ej_q.push_back(3'b010); ej_q.push_back(3'b001);
    sf_q.push_back(4'd1);
    run_req(4'd4, 0, 1'b0, 1'b0);
    chk("inv1_second_inv_empty", ie_m, 3'b111);
    step();
    chk("shortfall_held", sf_m, 4'd1);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end

endmodule
